// File: rtl/spi_buf_pkg.sv
// Shared types and helpers for the SPI receive-frame assembler.
package spi_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_HOLD
    } state_t;

    localparam int HDR_FIELD_W = 8;
    localparam int HDR_W       = 3 * HDR_FIELD_W;

    function automatic int frame_width(input int nbytes, input int xadc_w);
        return HDR_W + 8 * nbytes + xadc_w;
    endfunction

    // Unsigned range test done before any subtraction so the slot index never wraps.
    function automatic logic slot_in_window(input int unsigned addr,
                                            input int unsigned base,
                                            input int unsigned nbytes);
        return (addr >= base) && (addr < base + nbytes);
    endfunction

endpackage

// File: rtl/frame_timeout_cnt.sv
// Idle-cycle counter for the FILL state; expire fires in the cycle whose
// idle edge would bring the count up to TIMEOUT_CYC.
module frame_timeout_cnt #(
    parameter  int TIMEOUT_CYC = 1024,
    localparam int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] count;

    assign expire = enable && (count == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_frame_assembler.sv
// Collects addressed SPI payload bytes into slots and emits a packed frame
// (header, slots, xadc) upstream through a valid/ready handshake.
module spi_frame_assembler
    import spi_buf_pkg::*;
#(
    parameter  int NBYTES      = 5,
    parameter  int ADDR_W      = 5,
    parameter  int BASE_ADDR   = 3,
    parameter  int XADC_W      = 12,
    parameter  int TIMEOUT_CYC = 1024,
    localparam int FRAME_W     = frame_width(NBYTES, XADC_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               byte_valid,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [7:0]         data_in,
    input  logic               frame_close,
    input  logic [7:0]         spi_id_in,
    input  logic [7:0]         spi_select,
    input  logic [7:0]         spi_reg,
    input  logic [XADC_W-1:0]  xadc_in,
    output logic [FRAME_W-1:0] frame_out,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic               frame_partial,
    output logic               err_addr,
    output logic               err_timeout,
    output logic               overflow
);

    state_t              state;
    logic [8*NBYTES-1:0] slot_bus;
    logic [8*NBYTES-1:0] slot_next;
    logic [NBYTES-1:0]   mask;
    logic [NBYTES-1:0]   mask_next;
    logic [ADDR_W-1:0]   slot_idx;
    logic [FRAME_W-1:0]  frame_next;
    logic                addr_ok;
    logic                in_win;
    logic                full;
    logic                expire;

    assign addr_ok  = slot_in_window(32'(addr), 32'(BASE_ADDR), 32'(NBYTES));
    assign in_win   = byte_valid && addr_ok;
    assign slot_idx = addr - ADDR_W'(BASE_ADDR);

    // In HOLD the next buffer is the fresh one a handshake-cycle byte lands in.
    always_comb begin
        slot_next = (state == ST_HOLD) ? '0 : slot_bus;
        mask_next = (state == ST_HOLD) ? '0 : mask;
        for (int k = 0; k < NBYTES; k++) begin
            if (in_win && (slot_idx == ADDR_W'(k))) begin
                slot_next[8*(NBYTES-1-k) +: 8] = data_in;
                mask_next[k]                   = 1'b1;
            end
        end
    end

    assign full       = &mask_next;
    assign frame_next = {spi_id_in, spi_select, spi_reg, slot_next, xadc_in};

    generate
        if (TIMEOUT_CYC > 0) begin : g_timeout
            frame_timeout_cnt #(
                .TIMEOUT_CYC(TIMEOUT_CYC)
            ) u_timeout (
                .clk   (clk),
                .rst   (rst),
                .clear (state != ST_FILL || in_win),
                .enable(state == ST_FILL && !in_win),
                .expire(expire)
            );
        end else begin : g_no_timeout
            assign expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            slot_bus      <= '0;
            mask          <= '0;
            frame_out     <= '0;
            frame_valid   <= 1'b0;
            frame_partial <= 1'b0;
            err_addr      <= 1'b0;
            err_timeout   <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            err_addr    <= byte_valid && !addr_ok;
            err_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_win) begin
                        slot_bus <= slot_next;
                        mask     <= mask_next;
                        if (full) begin
                            frame_out     <= frame_next;
                            frame_valid   <= 1'b1;
                            frame_partial <= 1'b0;
                            state         <= ST_HOLD;
                        end else begin
                            state <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (in_win) begin
                        slot_bus <= slot_next;
                        mask     <= mask_next;
                    end
                    if (full || frame_close) begin
                        frame_out     <= frame_next;
                        frame_valid   <= 1'b1;
                        frame_partial <= !full;
                        state         <= ST_HOLD;
                    end else if (expire) begin
                        slot_bus    <= '0;
                        mask        <= '0;
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (frame_ready) begin
                        slot_bus      <= slot_next;
                        mask          <= mask_next;
                        frame_valid   <= 1'b0;
                        frame_partial <= 1'b0;
                        if (!in_win) begin
                            state <= ST_IDLE;
                        end else if (full) begin
                            frame_out   <= frame_next;
                            frame_valid <= 1'b1;
                            state       <= ST_HOLD;
                        end else begin
                            state <= ST_FILL;
                        end
                    end else if (in_win) begin
                        overflow <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_assembler.sv
// Scoreboard bench: a default-geometry DUT (short timeout) and a 2-slot,
// 10-bit-xadc DUT with the timeout omitted.
module tb_spi_frame_assembler;

    typedef struct packed {
        logic [75:0] frame;
        logic        partial;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        byte_valid  = 1'b0;
    logic [4:0]  addr        = '0;
    logic [7:0]  data_in     = '0;
    logic        frame_close = 1'b0;
    logic        frame_ready = 1'b0;
    logic [7:0]  spi_id      = 8'h11;
    logic [7:0]  spi_sel     = 8'h22;
    logic [7:0]  spi_reg     = 8'h33;
    logic [11:0] xadc        = 12'hABC;
    logic [75:0] frame_out;
    logic        frame_valid, frame_partial, err_addr, err_timeout, overflow;

    logic        b_byte_valid  = 1'b0;
    logic [4:0]  b_addr        = '0;
    logic [7:0]  b_data_in     = '0;
    logic        b_frame_close = 1'b0;
    logic        b_frame_ready = 1'b1;
    logic [9:0]  b_xadc        = 10'h2F5;
    logic [49:0] b_frame_out;
    logic        b_frame_valid, b_frame_partial, b_err_addr, b_err_timeout, b_overflow;

    exp_t        exp_q[$];
    logic [49:0] b_exp_q[$];
    int          checks = 0;
    int          errors = 0;

    spi_frame_assembler #(
        .TIMEOUT_CYC(16)
    ) dut_a (
        .clk          (clk),
        .rst          (rst),
        .byte_valid   (byte_valid),
        .addr         (addr),
        .data_in      (data_in),
        .frame_close  (frame_close),
        .spi_id_in    (spi_id),
        .spi_select   (spi_sel),
        .spi_reg      (spi_reg),
        .xadc_in      (xadc),
        .frame_out    (frame_out),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_partial(frame_partial),
        .err_addr     (err_addr),
        .err_timeout  (err_timeout),
        .overflow     (overflow)
    );

    spi_frame_assembler #(
        .NBYTES     (2),
        .BASE_ADDR  (0),
        .XADC_W     (10),
        .TIMEOUT_CYC(0)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .byte_valid   (b_byte_valid),
        .addr         (b_addr),
        .data_in      (b_data_in),
        .frame_close  (b_frame_close),
        .spi_id_in    (8'h01),
        .spi_select   (8'h02),
        .spi_reg      (8'h03),
        .xadc_in      (b_xadc),
        .frame_out    (b_frame_out),
        .frame_valid  (b_frame_valid),
        .frame_ready  (b_frame_ready),
        .frame_partial(b_frame_partial),
        .err_addr     (b_err_addr),
        .err_timeout  (b_err_timeout),
        .overflow     (b_overflow)
    );

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] a, input logic [7:0] d, input logic c);
        byte_valid  = v;
        addr        = a;
        data_in     = d;
        frame_close = c;
        tick();
        byte_valid  = 1'b0;
        addr        = '0;
        data_in     = '0;
        frame_close = 1'b0;
    endtask

    function automatic exp_t make_exp(input logic [39:0] slots, input logic partial);
        exp_t e;
        e.frame   = {8'h11, 8'h22, 8'h33, slots, 12'hABC};
        e.partial = partial;
        return e;
    endfunction

    // Pops on every accepted frame; while held, frame_out must match the head.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && frame_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_frame", 128'(frame_valid), 128'(0));
            end else if (frame_ready) begin
                e = exp_q.pop_front();
                checkOutput("frame_out", 128'(frame_out), 128'(e.frame));
                checkOutput("frame_partial", 128'(frame_partial), 128'(e.partial));
            end else begin
                checkOutput("frame_hold", 128'(frame_out), 128'(exp_q[0].frame));
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1 && b_frame_valid === 1'b1) begin
            if (b_exp_q.size() == 0) begin
                checkOutput("b_unexpected_frame", 128'(b_frame_valid), 128'(0));
            end else if (b_frame_ready) begin
                checkOutput("b_frame_out", 128'(b_frame_out), 128'(b_exp_q.pop_front()));
                checkOutput("b_frame_partial", 128'(b_frame_partial), 128'(0));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int order[5] = '{7, 5, 3, 6, 4};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_frame_out", 128'(frame_out), 128'(0));
        checkOutput("rst_frame_valid", 128'(frame_valid), 128'(0));
        checkOutput("rst_partial", 128'(frame_partial), 128'(0));
        checkOutput("rst_err_addr", 128'(err_addr), 128'(0));
        checkOutput("rst_err_timeout", 128'(err_timeout), 128'(0));
        checkOutput("rst_overflow", 128'(overflow), 128'(0));
        checkOutput("b_rst_frame_out", 128'(b_frame_out), 128'(0));
        checkOutput("b_rst_flags", 128'({b_frame_valid, b_err_addr, b_err_timeout, b_overflow}), 128'(0));
        rst = 1'b1;
        tick();

        // In-order frame, ready high.
        frame_ready = 1'b1;
        exp_q.push_back(make_exp(40'hA1A2A3A4A5, 1'b0));
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 5'(3 + i), 8'(8'hA1 + i), 1'b0);
        checkOutput("valid_rise", 128'(frame_valid), 128'(1));
        tick();
        checkOutput("valid_one_cycle", 128'(frame_valid), 128'(0));

        // Out-of-order frame held for four cycles, next frame starts on the handshake.
        frame_ready = 1'b0;
        exp_q.push_back(make_exp(40'hB3B4B5B6B7, 1'b0));
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 5'(order[i]), 8'(8'hB0 + order[i]), 1'b0);
        checkOutput("valid_hold", 128'(frame_valid), 128'(1));
        repeat (4) tick();
        checkOutput("valid_still", 128'(frame_valid), 128'(1));
        frame_ready = 1'b1;
        exp_q.push_back(make_exp(40'hC1C2C3C4C5, 1'b0));
        applyStimulus(1'b1, 5'd3, 8'hC1, 1'b0);
        checkOutput("valid_after_hs", 128'(frame_valid), 128'(0));
        for (int i = 1; i < 5; i++) applyStimulus(1'b1, 5'(3 + i), 8'(8'hC1 + i), 1'b0);
        checkOutput("c_valid", 128'(frame_valid), 128'(1));
        tick();

        // Partial close; close in IDLE ignored; completing byte with close.
        applyStimulus(1'b0, 5'd0, 8'h00, 1'b1);
        checkOutput("close_idle", 128'(frame_valid), 128'(0));
        exp_q.push_back(make_exp(40'hA1A2000000, 1'b1));
        applyStimulus(1'b1, 5'd3, 8'hA1, 1'b0);
        applyStimulus(1'b1, 5'd4, 8'hA2, 1'b0);
        applyStimulus(1'b0, 5'd0, 8'h00, 1'b1);
        checkOutput("partial_valid", 128'(frame_valid), 128'(1));
        tick();
        exp_q.push_back(make_exp(40'hD1D2D3D4D5, 1'b0));
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5'(3 + i), 8'(8'hD1 + i), 1'b0);
        applyStimulus(1'b1, 5'd7, 8'hD5, 1'b1);
        checkOutput("close_full_valid", 128'(frame_valid), 128'(1));
        tick();

        // Address errors and overflow.
        frame_ready = 1'b0;
        applyStimulus(1'b1, 5'd2, 8'h99, 1'b0);
        checkOutput("err_addr_low", 128'(err_addr), 128'(1));
        checkOutput("no_state_low", 128'(frame_valid), 128'(0));
        tick();
        checkOutput("err_addr_pulse", 128'(err_addr), 128'(0));
        exp_q.push_back(make_exp(40'hE1E2E3E4E5, 1'b0));
        applyStimulus(1'b1, 5'd3, 8'hE1, 1'b0);
        applyStimulus(1'b1, 5'd8, 8'h77, 1'b0);
        checkOutput("err_addr_high", 128'(err_addr), 128'(1));
        for (int i = 1; i < 5; i++) applyStimulus(1'b1, 5'(3 + i), 8'(8'hE1 + i), 1'b0);
        checkOutput("e_valid", 128'(frame_valid), 128'(1));
        applyStimulus(1'b1, 5'd3, 8'hFF, 1'b0);
        checkOutput("overflow_set", 128'(overflow), 128'(1));
        frame_ready = 1'b1;
        tick();
        checkOutput("e_done", 128'(frame_valid), 128'(0));
        tick();
        checkOutput("overflow_sticky", 128'(overflow), 128'(1));

        // Timeout abort clears the buffer; a byte on the expiry cycle wins.
        applyStimulus(1'b1, 5'd3, 8'hF1, 1'b0);
        repeat (15) tick();
        checkOutput("no_timeout_early", 128'(err_timeout), 128'(0));
        tick();
        checkOutput("timeout_pulse", 128'(err_timeout), 128'(1));
        tick();
        checkOutput("timeout_one_cycle", 128'(err_timeout), 128'(0));
        exp_q.push_back(make_exp(40'h00F2F3F4F5, 1'b1));
        for (int i = 1; i < 5; i++) applyStimulus(1'b1, 5'(3 + i), 8'(8'hF1 + i), 1'b0);
        checkOutput("after_timeout_fill", 128'(frame_valid), 128'(0));
        applyStimulus(1'b0, 5'd0, 8'h00, 1'b1);
        checkOutput("after_timeout_close", 128'(frame_valid), 128'(1));
        tick();
        applyStimulus(1'b1, 5'd3, 8'h31, 1'b0);
        repeat (15) tick();
        applyStimulus(1'b1, 5'd4, 8'h32, 1'b0);
        checkOutput("expiry_byte_wins", 128'(err_timeout), 128'(0));
        repeat (15) tick();
        checkOutput("restart_early", 128'(err_timeout), 128'(0));
        tick();
        checkOutput("restart_timeout", 128'(err_timeout), 128'(1));

        // Reset mid-FILL discards the partial buffer and clears overflow.
        applyStimulus(1'b1, 5'd3, 8'h51, 1'b0);
        applyStimulus(1'b1, 5'd4, 8'h52, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checkOutput("rst_fill_valid", 128'(frame_valid), 128'(0));
        checkOutput("rst_fill_out", 128'(frame_out), 128'(0));
        checkOutput("rst_overflow_clear", 128'(overflow), 128'(0));
        exp_q.push_back(make_exp(40'h0000535455, 1'b1));
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 5'(5 + i), 8'(8'h53 + i), 1'b0);
        checkOutput("rst_fill_discard", 128'(frame_valid), 128'(0));
        applyStimulus(1'b0, 5'd0, 8'h00, 1'b1);
        checkOutput("rst_fill_close", 128'(frame_valid), 128'(1));
        tick();

        // Reset mid-HOLD drops frame_valid on the next edge.
        frame_ready = 1'b0;
        exp_q.push_back(make_exp(40'h6162636465, 1'b0));
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 5'(3 + i), 8'(8'h61 + i), 1'b0);
        checkOutput("hold_valid", 128'(frame_valid), 128'(1));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checkOutput("rst_hold_valid", 128'(frame_valid), 128'(0));
        void'(exp_q.pop_front());

        // Narrow geometry: two slots at address 0, 10-bit xadc.
        b_exp_q.push_back({8'h01, 8'h02, 8'h03, 8'h5A, 8'hC3, 10'h2F5});
        b_byte_valid = 1'b1;
        b_addr       = 5'd1;
        b_data_in    = 8'hC3;
        tick();
        b_addr       = 5'd0;
        b_data_in    = 8'h5A;
        tick();
        b_byte_valid = 1'b0;
        checkOutput("b_valid", 128'(b_frame_valid), 128'(1));
        tick();
        b_byte_valid = 1'b1;
        b_addr       = 5'd2;
        tick();
        b_byte_valid = 1'b0;
        checkOutput("b_err_addr", 128'(b_err_addr), 128'(1));
        checkOutput("b_no_frame", 128'(b_frame_valid), 128'(0));
        tick();

        checkOutput("queue_empty", 128'(exp_q.size()), 128'(0));
        checkOutput("b_queue_empty", 128'(b_exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
